// File: rtl/seq_pattern_sender_pkg.sv
// Shared types and helpers for the 1/2/3 run-pattern sender.
// Holds the phase encoding, the symbol constants and the phase-ordering helpers.
package seq_pattern_sender_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRun1 = 3'd1,
    StRun2 = 3'd2,
    StRun3 = 3'd3,
    StTail = 3'd4
  } state_e;

  localparam logic [1:0] SymNone  = 2'd0;
  localparam logic [1:0] SymOne   = 2'd1;
  localparam logic [1:0] SymTwo   = 2'd2;
  localparam logic [1:0] SymThree = 2'd3;

  // Next phase after cur whose count is nonzero; nz[k-1] flags cntk != 0.
  function automatic state_e next_phase(state_e cur, logic [2:0] nz);
    if (cur == StIdle && nz[0]) return StRun1;
    if ((cur == StIdle || cur == StRun1) && nz[1]) return StRun2;
    if ((cur == StIdle || cur == StRun1 || cur == StRun2) && nz[2]) return StRun3;
    return StTail;
  endfunction

  function automatic logic [1:0] sym_of(state_e st);
    unique case (st)
      StRun1:  return SymOne;
      StRun2:  return SymTwo;
      StRun3:  return SymThree;
      default: return SymNone;
    endcase
  endfunction

endpackage

// File: rtl/seq_pattern_sender_run_counter.sv
// Loadable down-counter timing the length of one run phase.
// last_o flags the final cycle of the phase (count of one remaining).
module seq_pattern_sender_run_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          last_o
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && count_q != '0) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign last_o = (count_q == CW'(1));

endmodule

// File: rtl/seq_pattern_sender.sv
// Emits framed symbol patterns: cnt1 x '1', cnt2 x '2', cnt3 x '3', then one '0' tail.
// All outputs are registered; zero-length phases are skipped without bubbles.
module seq_pattern_sender
  import seq_pattern_sender_pkg::*;
#(
  parameter int unsigned CW = 4,
  parameter int unsigned FW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [CW-1:0] cnt1_i,
  input  logic [CW-1:0] cnt2_i,
  input  logic [CW-1:0] cnt3_i,
  output logic [1:0]    num_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [FW-1:0] frames_o
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt1_q, cnt2_q, cnt3_q;
  logic [1:0]    num_q;
  logic          busy_q, done_q;
  logic [FW-1:0] frames_q;

  logic          accept;
  logic          load;
  logic [CW-1:0] load_val;
  logic          last;
  logic          in_run;
  logic [2:0]    nz_in, nz_q;

  assign accept = (state_q == StIdle) && start_i;
  assign in_run = (state_q == StRun1) || (state_q == StRun2) || (state_q == StRun3);
  assign nz_in  = {cnt3_i != '0, cnt2_i != '0, cnt1_i != '0};
  assign nz_q   = {cnt3_q != '0, cnt2_q != '0, cnt1_q != '0};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_i) state_d = next_phase(StIdle, nz_in);
      StRun1, StRun2, StRun3: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (last) begin
          state_d = next_phase(state_q, nz_q);
        end
      end
      StTail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Entering a run phase always comes from a different state, so reload on entry.
  always_comb begin
    load_val = '0;
    unique case (state_d)
      StRun1:  load_val = accept ? cnt1_i : cnt1_q;
      StRun2:  load_val = accept ? cnt2_i : cnt2_q;
      StRun3:  load_val = accept ? cnt3_i : cnt3_q;
      default: load_val = '0;
    endcase
    load = (state_d != state_q) &&
           (state_d == StRun1 || state_d == StRun2 || state_d == StRun3);
  end

  seq_pattern_sender_run_counter #(
    .CW (CW)
  ) u_run_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .load_val_i (load_val),
    .dec_i      (in_run),
    .last_o     (last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt1_q   <= '0;
      cnt2_q   <= '0;
      cnt3_q   <= '0;
      num_q    <= SymNone;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= sym_of(state_d);
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StTail);
      if (state_d == StTail) frames_q <= frames_q + FW'(1);
      if (accept) begin
        cnt1_q <= cnt1_i;
        cnt2_q <= cnt2_i;
        cnt3_q <= cnt3_i;
      end
    end
  end

  assign num_o    = num_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign frames_o = frames_q;

endmodule

// File: tb/tb_seq_pattern_sender.sv
// Self-checking bench for seq_pattern_sender: directed frames plus random traffic
// compared cycle by cycle against a queue-based model of the symbol stream.
module tb_seq_pattern_sender;

  localparam int unsigned CW = 4;
  localparam int unsigned FW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] cnt1 = '0, cnt2 = '0, cnt3 = '0;
  logic [1:0]    num;
  logic          busy, done;
  logic [FW-1:0] frames;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: symbols still to be shown after the current one.
  int m_rem[$];
  int m_sym    = 0;
  bit m_busy   = 0;
  bit m_done   = 0;
  int m_frames = 0;

  int cyc = 0;

  seq_pattern_sender #(
    .CW (CW),
    .FW (FW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .abort_i  (abort),
    .cnt1_i   (cnt1),
    .cnt2_i   (cnt2),
    .cnt3_i   (cnt3),
    .num_o    (num),
    .busy_o   (busy),
    .done_o   (done),
    .frames_o (frames)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    m_rem.delete();
    m_sym  = 0;
    m_busy = 0;
    m_done = 0;
    m_frames = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    if (!m_busy) begin
      if (start) begin
        for (int i = 0; i < int'(cnt1); i++) m_rem.push_back(1);
        for (int i = 0; i < int'(cnt2); i++) m_rem.push_back(2);
        for (int i = 0; i < int'(cnt3); i++) m_rem.push_back(3);
        m_rem.push_back(0);
        m_sym  = m_rem.pop_front();
        m_busy = 1;
      end
    end else if (m_rem.size() == 0) begin
      m_busy = 0;
      m_sym  = 0;
    end else if (abort) begin
      m_rem.delete();
      m_busy = 0;
      m_sym  = 0;
    end else begin
      m_sym = m_rem.pop_front();
    end
    m_done = m_busy && (m_rem.size() == 0);
    if (m_done) m_frames = (m_frames + 1) % (1 << FW);
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, "_num"}, int'(num), m_sym);
    check_eq({tag, "_busy"}, int'(busy), int'(m_busy));
    check_eq({tag, "_done"}, int'(done), int'(m_done));
    check_eq({tag, "_frames"}, int'(frames), m_frames);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare_all(tag);
  endtask

  task automatic set_in(input bit s, input bit a, input int c1, input int c2, input int c3);
    start = s;
    abort = a;
    cnt1  = CW'(c1);
    cnt2  = CW'(c2);
    cnt3  = CW'(c3);
  endtask

  int done_at[$];
  int guard;

  initial begin
    rst = 1'b1;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;
    cycle("idle");

    // (1,1,1): 1,2,3,0 with done on the tail only
    set_in(1, 0, 1, 1, 1);
    cycle("f111");
    check_eq("f111_first", int'(num), 1);
    set_in(0, 0, 9, 9, 9);
    for (int i = 0; i < 4; i++) cycle("f111");

    // (2,0,3): no '2' symbol, six busy cycles
    set_in(1, 0, 2, 0, 3);
    cycle("f203");
    set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle("f203");

    // (0,0,0): tail only
    set_in(1, 1, 0, 0, 0);
    cycle("f000");
    check_eq("f000_done", int'(done), 1);
    set_in(0, 0, 0, 0, 0);
    cycle("f000");

    // (1,3,1) aborted on the second RUN2 cycle
    set_in(1, 0, 1, 3, 1);
    cycle("abort");
    set_in(0, 0, 1, 3, 1);
    cycle("abort");
    cycle("abort");
    check_eq("abort_run2", int'(num), 2);
    abort = 1'b1;
    cycle("abort");
    check_eq("abort_idle", int'(busy), 0);
    abort = 1'b0;
    cycle("abort");

    // start held high: frames every 5 cycles
    set_in(1, 0, 1, 1, 1);
    for (int i = 0; i < 16; i++) begin
      cycle("held");
      if (done) done_at.push_back(cyc);
    end
    set_in(0, 0, 0, 0, 0);
    cycle("held");
    check_eq("held_frames", done_at.size(), 3);
    if (done_at.size() >= 2) check_eq("held_spacing", done_at[1] - done_at[0], 5);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        cnt1 = CW'($urandom_range(0, 15));
        cnt2 = CW'($urandom_range(0, 15));
        cnt3 = CW'($urandom_range(0, 15));
      end else begin
        cnt1 = CW'($urandom_range(0, 3));
        cnt2 = CW'($urandom_range(0, 3));
        cnt3 = CW'($urandom_range(0, 3));
      end
      cycle("rand");
    end
    set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle("drain");

    // run frame counter up to all-ones and across the wrap
    set_in(1, 0, 0, 0, 0);
    guard = 0;
    while (m_frames != (1 << FW) - 1 && guard < 700) begin
      cycle("wrap");
      guard++;
    end
    check_eq("wrap_reached", m_frames, (1 << FW) - 1);
    check_eq("wrap_top", int'(frames), (1 << FW) - 1);
    cycle("wrap");
    cycle("wrap");
    check_eq("wrap_zero", int'(frames), 0);
    set_in(0, 0, 0, 0, 0);
    cycle("wrap");

    // make frames nonzero, then reset asynchronously in the middle of RUN2
    set_in(1, 0, 0, 0, 0);
    cycle("pre");
    set_in(0, 0, 0, 0, 0);
    cycle("pre");
    set_in(1, 0, 0, 5, 0);
    cycle("midrst");
    set_in(0, 0, 0, 5, 0);
    cycle("midrst");
    check_eq("midrst_run2", int'(num), 2);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("midrst_num", int'(num), 0);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_frames", int'(frames), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle("postrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
